// File: rtl/ofifo_writeback_if.sv
// ----------------------------------------------------------------------------
// ofifo_writeback_if
// Groups the signals between the writeback stage and its surroundings.
// The clock and reset are not part of this interface.
//   Control in   : start, base_addr
//   Stream in    : in (col x bw word), i_valid
//   Memory port  : mem_ready (in), mem_wen / mem_addr / mem_data (out)
//   Status out   : busy, done, overflow
// modport slave  : the writeback stage (ofifo_writeback)
// modport master : whoever drives the stream, controls the tile and models the SRAM
// ----------------------------------------------------------------------------
interface ofifo_writeback_if #(
    parameter int col    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11
);
    logic                       start;
    logic [addr_w-1:0]          base_addr;
    logic [col-1:0][bw-1:0]     in;
    logic                       i_valid;
    logic                       mem_ready;
    logic                       mem_wen;
    logic [addr_w-1:0]          mem_addr;
    logic [col-1:0][bw-1:0]     mem_data;
    logic                       busy;
    logic                       done;
    logic                       overflow;

    modport slave (
        input  start, base_addr, in, i_valid, mem_ready,
        output mem_wen, mem_addr, mem_data, busy, done, overflow
    );

    modport master (
        output start, base_addr, in, i_valid, mem_ready,
        input  mem_wen, mem_addr, mem_data, busy, done, overflow
    );
endinterface

// File: rtl/ofifo_writeback.sv
// ----------------------------------------------------------------------------
// ofifo_writeback
// Downstream stage of the SFU row. It takes nij_len output words, one per
// i_valid cycle, and writes them to consecutive output SRAM addresses starting
// at base_addr. The SFU row cannot stall, so a small FIFO (depth entries)
// absorbs SRAM back-pressure. Words that cannot be stored are dropped, and
// the sticky overflow flag records the drop.
//
// Ports
//   clk, reset  : clock; synchronous active-high reset
//   bus.slave   : start/base_addr (arms a tile in IDLE), in/i_valid (stream),
//                 mem_ready -> mem_wen/mem_addr/mem_data (SRAM write port,
//                 combinational from the FIFO head), busy/done/overflow
//
// Optional build macro
//   OFIFO_RELU_EN : when defined, each bw-bit lane of mem_data is treated as
//                   two's complement. Negative lanes are written as 0.
//                   The FIFO always stores raw values.
// ----------------------------------------------------------------------------
module ofifo_writeback #(
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int nij_len = 36,
    parameter int depth   = 4,
    parameter int addr_w  = 11
) (
    input  logic                clk,
    input  logic                reset,
    ofifo_writeback_if.slave    bus
);
    localparam int IDX_W = $clog2(depth);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(nij_len + 1);
    localparam logic [CNT_W-1:0] NIJ_LEN  = CNT_W'(nij_len);
    localparam logic [CNT_W-1:0] NIJ_LAST = CNT_W'(nij_len - 1);

    typedef logic [col-1:0][bw-1:0] word_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [addr_w-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    word_t               fifo_q [depth];
    word_t               fifo_d [depth];

    logic                empty_s, full_s, arm_s, pop_s, push_s, drop_s;
    word_t               head_s;

`ifdef OFIFO_RELU_EN
    // Clamp negative two's-complement lanes to zero.
    function automatic word_t relu_word(input word_t w);
        word_t r;
        for (int l = 0; l < col; l++) begin
            r[l] = w[l][bw-1] ? {bw{1'b0}} : w[l];
        end
        return r;
    endfunction
`endif

    // The extra pointer MSB tells a full FIFO from an empty one when the indices are equal.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign arm_s   = (state_q == S_IDLE) && bus.start;
    assign pop_s   = (state_q == S_RUN) && !empty_s && bus.mem_ready;
    // A full FIFO can still accept a word when its head leaves in the same cycle.
    assign push_s  = (state_q == S_RUN) && bus.i_valid && (in_cnt_q < NIJ_LEN) &&
                     (!full_s || pop_s);
    assign drop_s  = bus.i_valid && !push_s;
    assign head_s  = empty_s ? word_t'(0) : fifo_q[rd_ptr_q[IDX_W-1:0]];

    assign bus.mem_wen  = pop_s;
    assign bus.mem_addr = addr_q;
`ifdef OFIFO_RELU_EN
    assign bus.mem_data = relu_word(head_s);
`else
    assign bus.mem_data = head_s;
`endif
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.overflow = overflow_q;

    // Next-state logic: FSM, FIFO pointers and storage, address and counters.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        in_cnt_d   = in_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_d     = fifo_q;
        // Start clears the flag. A drop in the same cycle still sets it.
        overflow_d = (arm_s ? 1'b0 : overflow_q) | drop_s;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    addr_d   = bus.base_addr;
                    in_cnt_d = {CNT_W{1'b0}};
                    wr_cnt_d = {CNT_W{1'b0}};
                    wr_ptr_d = {PTR_W{1'b0}};
                    rd_ptr_d = {PTR_W{1'b0}};
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                if (push_s) begin
                    fifo_d[wr_ptr_q[IDX_W-1:0]] = bus.in;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                end else begin
                    wr_ptr_d = wr_ptr_q;
                    in_cnt_d = in_cnt_q;
                end
                if (pop_s) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    addr_d   = addr_q + addr_w'(1);
                    wr_cnt_d = (wr_cnt_q < NIJ_LEN) ? (wr_cnt_q + CNT_W'(1)) : wr_cnt_q;
                end else begin
                    rd_ptr_d = rd_ptr_q;
                    addr_d   = addr_q;
                    wr_cnt_d = wr_cnt_q;
                end
                if (pop_s && (wr_cnt_q == NIJ_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= {addr_w{1'b0}};
            in_cnt_q   <= {CNT_W{1'b0}};
            wr_cnt_q   <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            overflow_q <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                fifo_q[i] <= word_t'(0);
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            in_cnt_q   <= in_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_ofifo_writeback.sv
// ----------------------------------------------------------------------------
// tb_ofifo_writeback
// Directed scoreboard bench for ofifo_writeback. The stimulus pushes each
// expected SRAM write (address, data, cycle) into a queue. A negedge monitor
// pops the queue and compares on every mem_wen, and checks the done latency.
// ----------------------------------------------------------------------------
module tb_ofifo_writeback;
    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int NIJ = 36;
    localparam int DEP = 4;
    localparam int AW  = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     done_cnt = 0;
    int     last_wr_cyc = 0;
    bit     mon_en = 1'b0;
    exp_t   exp_q[$];
    exp_t   mon_e;

    ofifo_writeback_if #(.col(COL), .bw(BW), .addr_w(AW)) bus ();

    ofifo_writeback #(
        .col(COL), .bw(BW), .nij_len(NIJ), .depth(DEP), .addr_w(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference lane clamp, written independently of the RTL.
    function automatic logic [31:0] model_data(input logic [31:0] raw);
        logic [31:0] r;
        r = raw;
`ifdef OFIFO_RELU_EN
        for (int l = 0; l < COL; l++) begin
            if (raw[l*BW + BW - 1]) r[l*BW +: BW] = 4'h0;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] pat_word(input int k);
        logic [3:0] kk;
        kk = k[3:0];
        return {8{kk}} ^ 32'h1357_9BDF;
    endfunction

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_wen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%h expected none",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                    chk("wr_data", bus.mem_data, mon_e.data);
                    if (mon_e.cyc >= 0) chk("wr_latency", cyc, mon_e.cyc);
                end
                last_wr_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_latency", cyc, last_wr_cyc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        tick();
        bus.start     = 1'b0;
    endtask

    // Drive one input word. If it should be accepted, queue its write.
    task automatic send(input logic [31:0] w, input bit accept, input logic [AW-1:0] a,
                        input bit timed, input logic [31:0] expd);
        bus.in      = w;
        bus.i_valid = 1'b1;
        if (accept) exp_q.push_back('{a, expd, timed ? cyc + 1 : -1});
        tick();
        bus.i_valid = 1'b0;
    endtask

    // Full tile. stall_at >= 0 holds mem_ready low for three input cycles.
    task automatic run_tile(input logic [AW-1:0] base, input bit timed, input int stall_at);
        logic [AW-1:0] a;
        do_start(base);
        for (int k = 0; k < NIJ; k++) begin
            if (k == stall_at)     bus.mem_ready = 1'b0;
            if (k == stall_at + 3) bus.mem_ready = 1'b1;
            a = base + AW'(k);
            send(pat_word(k), 1'b1, a, timed, model_data(pat_word(k)));
        end
        bus.mem_ready = 1'b1;
    endtask

    initial begin
        int d0;
        logic [31:0] relu_in  [4];
        logic [31:0] relu_exp [4];
        relu_in[0] = 32'h8888_8888;
        relu_in[1] = 32'h7777_7777;
        relu_in[2] = 32'hFFFF_FFFF;
        relu_in[3] = 32'h87F0_F78F;
`ifdef OFIFO_RELU_EN
        relu_exp[0] = 32'h0000_0000;
        relu_exp[1] = 32'h7777_7777;
        relu_exp[2] = 32'h0000_0000;
        relu_exp[3] = 32'h0700_0700;
`else
        relu_exp[0] = 32'h8888_8888;
        relu_exp[1] = 32'h7777_7777;
        relu_exp[2] = 32'hFFFF_FFFF;
        relu_exp[3] = 32'h87F0_F78F;
`endif

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.in        = '0;
        bus.i_valid   = 1'b0;
        bus.mem_ready = 1'b1;
        idle(2);
        mon_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        chk("rst_wen",      32'(bus.mem_wen),  32'd0);
        chk("rst_addr",     32'(bus.mem_addr), 32'd0);
        chk("rst_data",     bus.mem_data,      32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        tick();

        // T1 streaming
        d0 = done_cnt;
        run_tile(11'd100, 1'b1, -1);
        idle(4);
        chk("t1_done",  done_cnt, d0 + 1);
        chk("t1_ovf",   32'(bus.overflow), 32'd0);
        chk("t1_drain", exp_q.size(), 0);
        chk("t1_busy",  32'(bus.busy), 32'd0);

        // T2 back-pressure
        d0 = done_cnt;
        run_tile(11'd200, 1'b0, 10);
        idle(8);
        chk("t2_done",  done_cnt, d0 + 1);
        chk("t2_ovf",   32'(bus.overflow), 32'd0);
        chk("t2_drain", exp_q.size(), 0);

        // T3 overflow: six words against a stalled memory, last two dropped
        d0 = done_cnt;
        do_start(11'd300);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(pat_word(k), (k < 4), 11'd300 + AW'(k), 1'b0, model_data(pat_word(k)));
        end
        bus.mem_ready = 1'b1;
        idle(6);
        chk("t3_ovf",   32'(bus.overflow), 32'd1);
        chk("t3_done",  done_cnt, d0);
        chk("t3_busy",  32'(bus.busy), 32'd1);
        chk("t3_drain", exp_q.size(), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // T4 address wrap
        d0 = done_cnt;
        run_tile(11'd2046, 1'b1, -1);
        idle(4);
        chk("t4_done",  done_cnt, d0 + 1);
        chk("t4_drain", exp_q.size(), 0);

        // T5 ReLU lanes (hand-computed expected words)
        d0 = done_cnt;
        do_start(11'd500);
        for (int k = 0; k < NIJ; k++) begin
            if (k < 4) send(relu_in[k], 1'b1, 11'd500 + AW'(k), 1'b1, relu_exp[k]);
            else       send(pat_word(k), 1'b1, 11'd500 + AW'(k), 1'b1, model_data(pat_word(k)));
        end
        idle(4);
        chk("t5_done",  done_cnt, d0 + 1);
        chk("t5_drain", exp_q.size(), 0);

        // T6 reset during the tile, a stray word in IDLE, then a clean tile
        d0 = done_cnt;
        do_start(11'd600);
        for (int k = 0; k < 10; k++) begin
            send(pat_word(k), 1'b1, 11'd600 + AW'(k), 1'b1, model_data(pat_word(k)));
        end
        bus.in      = pat_word(10);
        bus.i_valid = 1'b1;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("t6_rst_wen",  32'(bus.mem_wen),  32'd0);
        chk("t6_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_rst_data", bus.mem_data,      32'd0);
        chk("t6_rst_busy", 32'(bus.busy),     32'd0);
        chk("t6_rst_ovf",  32'(bus.overflow), 32'd0);
        tick();
        send(pat_word(3), 1'b0, 11'd0, 1'b0, 32'd0);
        chk("t6_idle_ovf",  32'(bus.overflow), 32'd1);
        chk("t6_idle_busy", 32'(bus.busy),     32'd0);
        idle(3);
        chk("t6_no_done", done_cnt, d0);
        do_start(11'd700);
        chk("t6_start_clr", 32'(bus.overflow), 32'd0);
        for (int k = 0; k < NIJ; k++) begin
            send(pat_word(k), 1'b1, 11'd700 + AW'(k), 1'b1, model_data(pat_word(k)));
        end
        idle(4);
        chk("t6_done",  done_cnt, d0 + 1);
        chk("t6_ovf",   32'(bus.overflow), 32'd0);
        chk("t6_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
